down_counter4b: RTL and testbench

Loadable synchronous down counter / interval timer, the counting-down counterpart of the team's 4-bit ripple-carry up counter. Counts a loaded value down to zero, one step per enabled clock. Signals terminal count (`Bc`) and completion (`done`). Optionally reloads automatically, so it can also act as a programmable clock-enable divider. Sits beside the up counter in the counter lab designs and feeds the same display/LED logic.

---
 rtl/down_counter4b.sv | 91 +++++++++
 tb/tb_down_counter4b.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/down_counter4b.sv
// down_counter4b: loadable synchronous down counter / interval timer.
// Counts a loaded start value down to zero, one step per enabled clock.
// Bc flags a zero count combinationally; done is a one-cycle registered pulse
// at the terminal step. With auto_reload set, the start value is reloaded at
// the terminal step, so the block doubles as a programmable enable divider.
module down_counter4b #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             en,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] Q,
    output logic             Bc,
    output logic             busy,
    output logic             done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    state_t           state_reg;
    state_t           state_next;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] rl_reg;      // last loaded start value, used for reloads
    logic [WIDTH-1:0] rl_next;
    logic             busy_reg;
    logic             done_reg;
    logic             done_next;

    // State, count, reload value and status flags; reset forces the idle zero state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            q_reg     <= ZERO;
            rl_reg    <= ZERO;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            q_reg     <= q_next;
            rl_reg    <= rl_next;
            busy_reg  <= (state_next == RUN);
            done_reg  <= done_next;
        end
    end

    // Next-state and next-count decode; load overrides every other action.
    always_comb begin
        state_next = state_reg;
        q_next     = q_reg;
        rl_next    = rl_reg;
        done_next  = 1'b0;

        if (load) begin
            q_next     = din;
            rl_next    = din;
            state_next = (din != ZERO) ? RUN : IDLE;
        end else if (state_reg == RUN && en) begin
            if (q_reg == ONE) begin
                // Terminal step: auto_reload is only looked at here.
                done_next = 1'b1;
                if (auto_reload) begin
                    q_next = rl_reg;
                end else begin
                    q_next     = ZERO;
                    state_next = IDLE;
                end
            end else if (q_reg == ZERO) begin
                // Not reachable through load; park safely instead of wrapping.
                state_next = IDLE;
            end else begin
                q_next = q_reg - ONE;
            end
        end
    end

    assign Q    = q_reg;
    assign Bc   = (q_reg == ZERO);
    assign busy = busy_reg;
    assign done = done_reg;

endmodule

// File: tb/tb_down_counter4b.sv
// tb_down_counter4b: directed scenarios plus random stimulus for down_counter4b,
// checked every cycle against an integer reference model and pinned by
// hand-computed expectations.
module tb_down_counter4b;

    localparam int WIDTH = 4;
    localparam int MAXV  = (1 << WIDTH) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             load = 1'b0;
    logic [WIDTH-1:0] din = '0;
    logic             en = 1'b0;
    logic             auto_reload = 1'b0;
    logic [WIDTH-1:0] Q;
    logic             Bc;
    logic             busy;
    logic             done;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state (plain integers).
    int m_count   = 0;
    int m_start   = 0;
    bit m_running = 1'b0;
    bit m_done    = 1'b0;

    down_counter4b #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .din         (din),
        .en          (en),
        .auto_reload (auto_reload),
        .Q           (Q),
        .Bc          (Bc),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Reference model: counts remaining steps; one-shot stops at zero,
    // auto-reload restarts from the saved start value.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_count   <= 0;
            m_start   <= 0;
            m_running <= 1'b0;
            m_done    <= 1'b0;
        end else if (load) begin
            m_count   <= int'(din);
            m_start   <= int'(din);
            m_running <= (din != 0);
            m_done    <= 1'b0;
        end else if (m_running && en) begin
            if (m_count == 1) begin
                m_done <= 1'b1;
                if (auto_reload) begin
                    m_count <= m_start;
                end else begin
                    m_count   <= 0;
                    m_running <= 1'b0;
                end
            end else begin
                m_count <= m_count - 1;
                m_done  <= 1'b0;
            end
        end else begin
            m_done <= 1'b0;
        end
    end

    // Every-cycle comparison against the model, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            n_checks++;
            if (int'(Q) != m_count || Bc != (m_count == 0) ||
                busy != m_running || done != m_done) begin
                n_fail++;
                $display("FAIL model t=%0t: Q=%0d Bc=%0b busy=%0b done=%0b, required Q=%0d Bc=%0b busy=%0b done=%0b",
                         $time, Q, Bc, busy, done, m_count, (m_count == 0), m_running, m_done);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // One clock: apply inputs, wait past the rising edge.
    task automatic cyc(input bit l, input int d, input bit e, input bit ar);
        load        = l;
        din         = WIDTH'(d);
        en          = e;
        auto_reload = ar;
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    initial begin
        int exp_ar[9];
        int exp_st[6];
        int en_st[6];
        int pulses;
        exp_ar = '{2, 1, 3, 2, 1, 3, 2, 1, 3};
        exp_st = '{3, 3, 3, 2, 1, 0};
        en_st  = '{1, 0, 0, 1, 1, 1};

        // Reset state
        #1;
        chk("reset_Q", int'(Q), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_Bc", int'(Bc), 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(0, 0, 1, 0);
        chk("idle_after_reset_Q", int'(Q), 0);

        // One-shot from 5
        cyc(1, 5, 0, 0);
        chk("oneshot_load_Q", int'(Q), 5);
        chk("oneshot_load_busy", int'(busy), 1);
        for (int v = 4; v >= 0; v--) begin
            cyc(0, 0, 1, 0);
            chk("oneshot_Q", int'(Q), v);
            chk("oneshot_done", int'(done), (v == 0) ? 1 : 0);
        end
        chk("oneshot_end_busy", int'(busy), 0);
        chk("oneshot_end_Bc", int'(Bc), 1);
        cyc(0, 0, 1, 0);
        chk("oneshot_done_clear", int'(done), 0);
        chk("oneshot_hold_Q", int'(Q), 0);
        $display("one-shot 5 complete");

        // Auto-reload from 3
        cyc(1, 3, 1, 1);
        chk("ar_load_Q", int'(Q), 3);
        for (int i = 0; i < 9; i++) begin
            cyc(0, 0, 1, 1);
            chk("ar_Q", int'(Q), exp_ar[i]);
            chk("ar_done", int'(done), (exp_ar[i] == 3) ? 1 : 0);
            chk("ar_Bc", int'(Bc), 0);
        end
        $display("auto-reload 3 complete");

        // Enable stall from 4
        cyc(1, 4, 0, 0);
        chk("stall_load_Q", int'(Q), 4);
        for (int i = 0; i < 6; i++) begin
            cyc(0, 0, en_st[i] != 0, 0);
            chk("stall_Q", int'(Q), exp_st[i]);
            chk("stall_done", int'(done), (i == 5) ? 1 : 0);
        end
        $display("enable stall complete");

        // Load priority over terminal step, then zero load
        cyc(1, 2, 0, 0);
        cyc(0, 0, 1, 0);
        chk("prio_pre_Q", int'(Q), 1);
        cyc(1, 7, 1, 0);
        chk("prio_Q", int'(Q), 7);
        chk("prio_done", int'(done), 0);
        chk("prio_busy", int'(busy), 1);
        cyc(1, 0, 1, 0);
        chk("zero_Q", int'(Q), 0);
        chk("zero_busy", int'(busy), 0);
        chk("zero_done", int'(done), 0);
        chk("zero_Bc", int'(Bc), 1);
        $display("load priority / zero load complete");

        // Full-scale one-shot
        cyc(1, MAXV, 0, 0);
        chk("full_load_Q", int'(Q), MAXV);
        pulses = 0;
        for (int i = 0; i < MAXV; i++) begin
            cyc(0, 0, 1, 0);
            pulses += int'(done);
        end
        chk("full_end_Q", int'(Q), 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 1, 0);
            pulses += int'(done);
            chk("full_nowrap_Q", int'(Q), 0);
        end
        chk("full_pulses", pulses, 1);
        $display("full-scale one-shot complete");

        // Reset mid-run
        cyc(1, 9, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0);
        chk("rstmid_pre_Q", int'(Q), 6);
        #2 rst = 1'b1;
        #1;
        chk("rstmid_Q", int'(Q), 0);
        chk("rstmid_busy", int'(busy), 0);
        chk("rstmid_done", int'(done), 0);
        chk("rstmid_Bc", int'(Bc), 1);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 1, 1);
            chk("rstmid_hold_Q", int'(Q), 0);
        end
        $display("reset mid-run complete");

        // Random stimulus, checked by the model every cycle
        for (int i = 0; i < 1500; i++) begin
            cyc(($urandom_range(0, 9) == 0), int'($urandom_range(0, MAXV)),
                ($urandom_range(0, 3) != 0), ($urandom_range(0, 1) == 1));
        end
        $display("random phase complete");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
